// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with a registered terminal-count pulse.
// It supports one-shot and auto-reload modes. All state is clocked on the rising edge of clk.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rld, rld_next;
    logic             tc_next;

    // State, count, reload value and tc pulse register; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            rld   <= rld_next;
            tc    <= tc_next;
        end
    end

    // Load takes priority over counting; tc is raised only on an enabled tick at q==1
    always_comb begin
        state_next = state;
        q_next     = q;
        rld_next   = rld;
        tc_next    = 1'b0;
        if (load) begin
            q_next     = load_val;
            rld_next   = load_val;
            state_next = (load_val != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (q == ONE) begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                q_next = rld;
                            end else begin
                                q_next     = '0;
                                state_next = DONE;
                            end
                        end else if (q != '0) begin
                            q_next = q - ONE;
                        end
                    end
                end
                DONE: begin
                    q_next = '0;
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
